multi_channel_modulator: RTL and testbench

//  Multi-channel carrier modulator for the test harness UART-controlled signal path.
//  - One shared square-wave carrier drives NUM_CH data channels.
//  - Each channel is keyed by one of four modes (OOK, inverted OOK, phase-invert,

---
 rtl/multi_channel_modulator.sv | 94 +++++++++
 tb/tb_multi_channel_modulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_modulator.sv
// rtl/multi_channel_modulator.sv - shared square-wave carrier keying NUM_CH data channels
// Config is double-buffered and swapped only on a carrier 1->0 wrap, so no partial period is emitted.

module multi_channel_modulator #(
   parameter int CTR_W        = 16,
   parameter int NUM_CH       = 4,
   parameter int RST_HALF_PER = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] in,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [CTR_W-1:0]  cfg_half_per,
   input  logic [1:0]        cfg_mode,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              carrier,
   output logic              period_tick,
   output logic [NUM_CH-1:0] out
);

   logic [CTR_W-1:0]  r_ctr;
   logic              r_carrier;
   logic              r_tick;
   logic [NUM_CH-1:0] r_out;
   logic              r_ready;
   logic [CTR_W-1:0]  r_hp;
   logic [1:0]        r_mode;
   logic [CTR_W-1:0]  r_pend_hp;
   logic [1:0]        r_pend_mode;

   logic [CTR_W-1:0]  w_hp_eff;
   logic              w_wrap;
   logic              w_c_nxt;
   logic              w_fall;
   logic              w_apply;
   logic [1:0]        w_mode_nxt;
   logic [NUM_CH-1:0] w_out_nxt;

   assign w_hp_eff   = (r_hp == '0) ? CTR_W'(1) : r_hp;
   assign w_wrap     = (r_ctr == w_hp_eff - CTR_W'(1));
   assign w_c_nxt    = r_carrier ^ w_wrap;
   assign w_fall     = w_wrap & r_carrier;
   assign w_apply    = w_fall & ~r_ready;
   // The period starting at the apply edge is already keyed with the new mode.
   assign w_mode_nxt = w_apply ? r_pend_mode : r_mode;

   always_comb begin
      w_out_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         case (w_mode_nxt)
            2'b00:   w_out_nxt[i] = ch_en[i] & in[i] & w_c_nxt;
            2'b01:   w_out_nxt[i] = ch_en[i] & ~in[i] & w_c_nxt;
            2'b10:   w_out_nxt[i] = ch_en[i] & (w_c_nxt ^ ~in[i]);
            default: w_out_nxt[i] = ch_en[i] & in[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctr       <= '0;
         r_carrier   <= 1'b0;
         r_tick      <= 1'b0;
         r_out       <= '0;
         r_ready     <= 1'b1;
         r_hp        <= CTR_W'(RST_HALF_PER);
         r_mode      <= 2'b00;
         r_pend_hp   <= '0;
         r_pend_mode <= 2'b00;
      end else begin
         r_ctr     <= w_wrap ? '0 : r_ctr + CTR_W'(1);
         r_carrier <= w_c_nxt;
         r_tick    <= w_fall;
         r_out     <= w_out_nxt;
         // Apply and capture are exclusive: apply needs a full holding register.
         if (w_apply) begin
            r_hp    <= r_pend_hp;
            r_mode  <= r_pend_mode;
            r_ready <= 1'b1;
         end else if (cfg_valid && r_ready) begin
            r_pend_hp   <= cfg_half_per;
            r_pend_mode <= cfg_mode;
            r_ready     <= 1'b0;
         end
      end
   end

   assign cfg_ready   = r_ready;
   assign carrier     = r_carrier;
   assign period_tick = r_tick;
   assign out         = r_out;

endmodule

// File: tb/tb_multi_channel_modulator.sv
// tb/tb_multi_channel_modulator.sv - randomized bench against a period-position reference model
// The model tracks position within the full carrier period rather than a half-period counter.

module tb_multi_channel_modulator;

   localparam int CTR_W  = 16;
   localparam int NUM_CH = 4;
   localparam int RST_HP = 8;

   logic              clk = 1'b0;
   logic              rst_d;
   logic [NUM_CH-1:0] in_d, en_d;
   logic [CTR_W-1:0]  hp_d;
   logic [1:0]        mode_d;
   logic              valid_d;
   logic              cfg_ready, carrier, period_tick;
   logic [NUM_CH-1:0] out_q;

   int n_tests = 0;
   int n_fail  = 0;

   int                m_t, m_hp, m_mode, m_pend_hp, m_pend_mode;
   logic              m_pend_full, m_car, m_tick;
   logic [NUM_CH-1:0] m_out;

   multi_channel_modulator #(.CTR_W(CTR_W), .NUM_CH(NUM_CH), .RST_HALF_PER(RST_HP)) dut (
      .clk(clk), .reset(rst_d), .in(in_d), .ch_en(en_d),
      .cfg_half_per(hp_d), .cfg_mode(mode_d), .cfg_valid(valid_d),
      .cfg_ready(cfg_ready), .carrier(carrier), .period_tick(period_tick), .out(out_q)
   );

   always #5 clk = ~clk;

   function automatic logic fmod(int mode, logic d, logic c);
      case (mode)
         0:       return d & c;
         1:       return !d & c;
         2:       return d ? c : !c;
         default: return d;
      endcase
   endfunction

   task automatic model_edge();
      int hpe, nt;
      logic acc;
      if (rst_d) begin
         m_t = 0; m_car = 0; m_tick = 0; m_out = '0;
         m_hp = RST_HP; m_mode = 0; m_pend_full = 0;
         return;
      end
      hpe = (m_hp == 0) ? 1 : m_hp;
      acc = valid_d && !m_pend_full;
      nt = m_t + 1;
      m_tick = 0;
      if (nt == 2 * hpe) begin
         nt = 0;
         m_tick = 1;
         if (m_pend_full) begin
            m_hp = m_pend_hp; m_mode = m_pend_mode; m_pend_full = 0;
         end
      end
      m_t = nt;
      m_car = (nt >= hpe);
      for (int i = 0; i < NUM_CH; i++) m_out[i] = en_d[i] & fmod(m_mode, in_d[i], m_car);
      if (acc) begin
         m_pend_hp = int'(hp_d); m_pend_mode = int'(mode_d); m_pend_full = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_d = 1; valid_d = 1; hp_d = 16'd2; mode_d = 2'b11; in_d = '1; en_d = '1;
      step(); step();
      n_tests++;
      if ({carrier, period_tick, cfg_ready, out_q} !== 7'b0010000) begin
         n_fail++;
         $display("FAIL reset_state: got car=%b tick=%b rdy=%b out=%b, want 0 0 1 0000",
                  carrier, period_tick, cfg_ready, out_q);
      end
      valid_d = 0; mode_d = 0;
      rst_d = 0;
   endtask

   task automatic test_ook_default();
      int highs = 0;
      in_d = '1; en_d = '1;
      for (int c = 0; c < 40; c++) begin
         step();
         if (carrier) highs++;
         n_tests++;
         if ({carrier, period_tick, cfg_ready, out_q} !== {m_car, m_tick, !m_pend_full, m_out}
             || out_q !== {NUM_CH{carrier}}) begin
            n_fail++;
            $display("FAIL ook_default c%0d: got %b %b %b %b, want %b %b %b %b", c,
                     carrier, period_tick, cfg_ready, out_q, m_car, m_tick, !m_pend_full, m_out);
         end
      end
      n_tests++;
      if (highs !== 17) begin
         n_fail++;
         $display("FAIL ook_high_count: got %0d, want 17", highs);
      end
   endtask

   task automatic test_cfg_apply(input int hp, input int mode, input int ncyc, input string nm);
      int guard = 0;
      while (!m_car && guard < 200) begin step(); guard++; end
      n_tests++;
      if (guard >= 200) begin
         n_fail++;
         $display("FAIL %s_wait: got carrier never high, want high", nm);
      end
      hp_d = CTR_W'(hp); mode_d = 2'(mode); valid_d = 1;
      step();
      valid_d = 0;
      for (int c = 0; c < ncyc; c++) begin
         n_tests++;
         if ({carrier, period_tick, cfg_ready, out_q} !== {m_car, m_tick, !m_pend_full, m_out}) begin
            n_fail++;
            $display("FAIL %s c%0d: got %b %b %b %b, want %b %b %b %b", nm, c,
                     carrier, period_tick, cfg_ready, out_q, m_car, m_tick, !m_pend_full, m_out);
         end
         step();
      end
   endtask

   task automatic test_phase_invert();
      test_cfg_apply(4, 2, 24, "pi_cfg");
      in_d[0] = 1;
      for (int c = 0; c < 20; c++) begin
         if (c == 11) in_d[0] = 0;
         step();
         n_tests++;
         if (out_q[0] !== (c >= 11 ? !carrier : carrier) || out_q !== m_out) begin
            n_fail++;
            $display("FAIL phase_invert c%0d: got out=%b car=%b, want out=%b", c, out_q, carrier, m_out);
         end
      end
      in_d = '1;
   endtask

   task automatic test_back_to_back();
      int accepted = 0;
      hp_d = 16'd5; mode_d = 2'b00; valid_d = 1;
      step();
      hp_d = 16'd2; mode_d = 2'b01;
      for (int c = 0; c < 60; c++) begin
         if (c > 0 && !m_pend_full && valid_d && accepted == 0) accepted = c;
         step();
         if (accepted != 0) valid_d = 0;
         n_tests++;
         if ({carrier, period_tick, cfg_ready, out_q} !== {m_car, m_tick, !m_pend_full, m_out}) begin
            n_fail++;
            $display("FAIL back_to_back c%0d: got %b %b %b %b, want %b %b %b %b", c,
                     carrier, period_tick, cfg_ready, out_q, m_car, m_tick, !m_pend_full, m_out);
         end
      end
      valid_d = 0;
      n_tests++;
      if (m_hp != 2 || accepted == 0) begin
         n_fail++;
         $display("FAIL back_to_back_final: got hp=%0d acc=%0d, want hp=2 acc>0", m_hp, accepted);
      end
   endtask

   task automatic test_reset_midway();
      rst_d = 1; step(); rst_d = 0;
      for (int c = 0; c < 5; c++) begin
         valid_d = (c == 2); hp_d = 16'd2; mode_d = 2'b10;
         step();
      end
      valid_d = 1; rst_d = 1;
      step();
      n_tests++;
      if ({carrier, period_tick, cfg_ready, out_q} !== 7'b0010000) begin
         n_fail++;
         $display("FAIL reset_midway: got car=%b tick=%b rdy=%b out=%b, want 0 0 1 0000",
                  carrier, period_tick, cfg_ready, out_q);
      end
      rst_d = 0; valid_d = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         n_tests++;
         if ({carrier, period_tick, cfg_ready, out_q} !== {m_car, m_tick, !m_pend_full, m_out}) begin
            n_fail++;
            $display("FAIL reset_period c%0d: got %b %b %b %b, want %b %b %b %b", c,
                     carrier, period_tick, cfg_ready, out_q, m_car, m_tick, !m_pend_full, m_out);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         in_d    = NUM_CH'($urandom);
         en_d    = NUM_CH'($urandom);
         valid_d = ($urandom_range(0, 7) == 0);
         hp_d    = CTR_W'($urandom_range(0, 5));
         mode_d  = 2'($urandom);
         rst_d   = ($urandom_range(0, 499) == 0);
         step();
         n_tests++;
         if ({carrier, period_tick, cfg_ready, out_q} !== {m_car, m_tick, !m_pend_full, m_out}) begin
            n_fail++;
            if (n_fail < 20)
               $display("FAIL random c%0d: got %b %b %b %b, want %b %b %b %b", c,
                        carrier, period_tick, cfg_ready, out_q, m_car, m_tick, !m_pend_full, m_out);
         end
      end
      rst_d = 0; valid_d = 0;
   endtask

   initial begin
      rst_d = 1; in_d = '0; en_d = '0; hp_d = '0; mode_d = 0; valid_d = 0;
      #1;
      test_reset();
      test_ook_default();
      test_cfg_apply(3, 0, 30, "hp3");
      test_cfg_apply(0, 0, 20, "hp0");
      test_phase_invert();
      test_back_to_back();
      test_reset_midway();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
